// File: rtl/regfile_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_arb_pkg : shared FSM state type and bus slicing helper        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package regfile_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RELEASE = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  // Low bit of client idx's field inside a flattened per-client vector.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_arbiter_if : client req/ack ports plus register-file command  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface regfile_arbiter_if #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 4,
  parameter int NumReq    = 2,
  parameter int IdxWidth  = $clog2(NumReq)
);
  logic [NumReq-1:0]           cli_req;
  logic [NumReq-1:0]           cli_ack;
  logic [NumReq-1:0]           cli_we;
  logic [NumReq*AddrWidth-1:0] cli_addr_w;
  logic [NumReq*AddrWidth-1:0] cli_addr_r1;
  logic [NumReq*AddrWidth-1:0] cli_addr_r2;
  logic [NumReq*DataWidth-1:0] cli_data_in;
  logic [DataWidth-1:0]        rdata1;
  logic [DataWidth-1:0]        rdata2;
  logic [IdxWidth-1:0]         grant_id;
  logic                        busy;
  logic                        rf_req;
  logic                        rf_ack;
  logic                        rf_we;
  logic [AddrWidth-1:0]        rf_addr_w;
  logic [AddrWidth-1:0]        rf_addr_r1;
  logic [AddrWidth-1:0]        rf_addr_r2;
  logic [DataWidth-1:0]        rf_data_in;
  logic [DataWidth-1:0]        rf_data_out1;
  logic [DataWidth-1:0]        rf_data_out2;

  // Arbiter side.
  modport master (
    input  cli_req, cli_we, cli_addr_w, cli_addr_r1, cli_addr_r2, cli_data_in,
    input  rf_ack, rf_data_out1, rf_data_out2,
    output cli_ack, rdata1, rdata2, grant_id, busy,
    output rf_req, rf_we, rf_addr_w, rf_addr_r1, rf_addr_r2, rf_data_in
  );

  // Clients and register file side.
  modport slave (
    output cli_req, cli_we, cli_addr_w, cli_addr_r1, cli_addr_r2, cli_data_in,
    output rf_ack, rf_data_out1, rf_data_out2,
    input  cli_ack, rdata1, rdata2, grant_id, busy,
    input  rf_req, rf_we, rf_addr_w, rf_addr_r1, rf_addr_r2, rf_data_in
  );
endinterface
`default_nettype wire

// File: rtl/regfile_arbiter_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin pick starting at ptr, wrapping |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module rr_arbiter #(
  parameter int NumReq   = 2,
  parameter int IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] ptr,
  output logic                gnt_valid,
  output logic [IdxWidth-1:0] gnt_idx
);

  int w_idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    w_idx     = 0;
    for (int off = 0; off < NumReq; off++) begin
      w_idx = int'(ptr) + off;
      if (w_idx >= NumReq) w_idx = w_idx - NumReq;
      if (!gnt_valid && req[IdxWidth'(w_idx)]) begin
        gnt_valid = 1'b1;
        gnt_idx   = IdxWidth'(w_idx);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | regfile_arbiter : round-robin sequencer sharing one four-phase        |
// |                   register file between NumReq clients              |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module regfile_arbiter
  import regfile_arb_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 4,
  parameter int NumReq    = 2,
  parameter int IdxWidth  = $clog2(NumReq)
) (
  input  logic                clk,
  input  logic                rst_n,
  regfile_arbiter_if.master   bus
);

  arb_state_t            r_state;
  arb_state_t            w_state_nxt;
  logic [IdxWidth-1:0]   r_rr_ptr;
  logic [IdxWidth-1:0]   r_grant_id;
  logic [IdxWidth-1:0]   w_ptr_nxt;
  logic                  r_rf_req;
  logic                  r_rf_we;
  logic [AddrWidth-1:0]  r_addr_w;
  logic [AddrWidth-1:0]  r_addr_r1;
  logic [AddrWidth-1:0]  r_addr_r2;
  logic [DataWidth-1:0]  r_data_in;
  logic [DataWidth-1:0]  r_rdata1;
  logic [DataWidth-1:0]  r_rdata2;
  logic [NumReq-1:0]     r_cli_ack;
  logic                  w_gnt_valid;
  logic [IdxWidth-1:0]   w_gnt_idx;
  logic                  w_grant;
  logic                  w_capture;
  logic                  w_release;
  logic                  w_finish;

  logic [AddrWidth-1:0]  w_cli_addr_w  [NumReq];
  logic [AddrWidth-1:0]  w_cli_addr_r1 [NumReq];
  logic [AddrWidth-1:0]  w_cli_addr_r2 [NumReq];
  logic [DataWidth-1:0]  w_cli_data_in [NumReq];

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_unpack
    assign w_cli_addr_w[gi]  = bus.cli_addr_w [slice_lo(gi, AddrWidth) +: AddrWidth];
    assign w_cli_addr_r1[gi] = bus.cli_addr_r1[slice_lo(gi, AddrWidth) +: AddrWidth];
    assign w_cli_addr_r2[gi] = bus.cli_addr_r2[slice_lo(gi, AddrWidth) +: AddrWidth];
    assign w_cli_data_in[gi] = bus.cli_data_in[slice_lo(gi, DataWidth) +: DataWidth];
  end

  rr_arbiter #(
    .NumReq   (NumReq),
    .IdxWidth (IdxWidth)
  ) u_rr (
    .req       (bus.cli_req),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_ptr_nxt = (r_grant_id == IdxWidth'(NumReq - 1)) ? '0 : r_grant_id + 1'b1;

  // A stale ack left over from before a reset blocks new grants.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: if (w_gnt_valid && !bus.rf_ack) begin
        w_grant     = 1'b1;
        w_state_nxt = ISSUE;
      end
      ISSUE: if (bus.rf_ack) begin
        w_capture   = 1'b1;
        w_state_nxt = RELEASE;
      end
      RELEASE: if (!bus.rf_ack) begin
        w_release   = 1'b1;
        w_state_nxt = DONE;
      end
      DONE: if (!bus.cli_req[r_grant_id]) begin
        w_finish    = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_rf_req   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_addr_w   <= '0;
      r_addr_r1  <= '0;
      r_addr_r2  <= '0;
      r_data_in  <= '0;
      r_rdata1   <= '0;
      r_rdata2   <= '0;
      r_cli_ack  <= '0;
    end else begin
      if (w_grant) begin
        r_grant_id <= w_gnt_idx;
        r_rf_we    <= bus.cli_we[w_gnt_idx];
        r_addr_w   <= w_cli_addr_w[w_gnt_idx];
        r_addr_r1  <= w_cli_addr_r1[w_gnt_idx];
        r_addr_r2  <= w_cli_addr_r2[w_gnt_idx];
        r_data_in  <= w_cli_data_in[w_gnt_idx];
        r_rf_req   <= 1'b1;
      end
      if (w_capture) begin
        r_rdata1 <= bus.rf_data_out1;
        r_rdata2 <= bus.rf_data_out2;
        r_rf_req <= 1'b0;
      end
      if (w_release) r_cli_ack[r_grant_id] <= 1'b1;
      if (w_finish) begin
        r_cli_ack <= '0;
        r_rr_ptr  <= w_ptr_nxt;
        r_rf_we   <= 1'b0;
      end
    end
  end

  assign bus.cli_ack    = r_cli_ack;
  assign bus.rdata1     = r_rdata1;
  assign bus.rdata2     = r_rdata2;
  assign bus.grant_id   = r_grant_id;
  assign bus.busy       = (r_state != IDLE);
  assign bus.rf_req     = r_rf_req;
  assign bus.rf_we      = r_rf_we;
  assign bus.rf_addr_w  = r_addr_w;
  assign bus.rf_addr_r1 = r_addr_r1;
  assign bus.rf_addr_r2 = r_addr_r2;
  assign bus.rf_data_in = r_data_in;

endmodule
`default_nettype wire

// File: tb/tb_regfile_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_regfile_arbiter : directed bench with a one-cycle-ack regfile model |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_regfile_arbiter;

  localparam int DW = 16;
  localparam int AW = 4;
  localparam int NR = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic tb_por;
  logic rf_hold;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  regfile_arbiter_if #(.DataWidth(DW), .AddrWidth(AW), .NumReq(NR)) bus ();

  regfile_arbiter #(.DataWidth(DW), .AddrWidth(AW), .NumReq(NR)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Register file: reads old contents and writes on the same edge it acks.
  logic [DW-1:0] mem [16];
  always @(posedge clk) begin
    if (tb_por) begin
      for (int i = 0; i < 16; i++) mem[i] <= '0;
      bus.rf_ack       <= 1'b0;
      bus.rf_data_out1 <= '0;
      bus.rf_data_out2 <= '0;
    end else if (bus.rf_req && !bus.rf_ack) begin
      bus.rf_data_out1 <= mem[bus.rf_addr_r1];
      bus.rf_data_out2 <= mem[bus.rf_addr_r2];
      if (bus.rf_we) mem[bus.rf_addr_w] <= bus.rf_data_in;
      bus.rf_ack <= 1'b1;
    end else if (!bus.rf_req && !rf_hold) begin
      bus.rf_ack <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_cli(input int id, input logic we, input logic [AW-1:0] aw,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic [DW-1:0] din);
    bus.cli_we[id]               = we;
    bus.cli_addr_w [id*AW +: AW] = aw;
    bus.cli_addr_r1[id*AW +: AW] = r1;
    bus.cli_addr_r2[id*AW +: AW] = r2;
    bus.cli_data_in[id*DW +: DW] = din;
  endtask

  task automatic wait_ack(input string tag, input int id, output int cyc);
    cyc = 0;
    while (bus.cli_ack[id] !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 32'(bus.cli_ack[id]), 32'd1);
  endtask

  task automatic drop(input string tag, input int id);
    bus.cli_req[id] = 1'b0;
    @(negedge clk);
    chk(tag, 32'(bus.cli_ack), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int cyc;
    int cnt;
    bus.cli_req     = '0;
    bus.cli_we      = '0;
    bus.cli_addr_w  = '0;
    bus.cli_addr_r1 = '0;
    bus.cli_addr_r2 = '0;
    bus.cli_data_in = '0;
    rf_hold = 1'b0;
    tb_por  = 1'b1;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",  32'(bus.busy),     32'd0);
    chk("rst_ack",   32'(bus.cli_ack),  32'd0);
    chk("rst_rfreq", 32'(bus.rf_req),   32'd0);
    chk("rst_gid",   32'(bus.grant_id), 32'd0);
    chk("rst_rd1",   32'(bus.rdata1),   32'd0);
    chk("rst_rfwe",  32'(bus.rf_we),    32'd0);
    tb_por = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);

    // Single write of 0xBEEF to r3; client inputs change after grant.
    set_cli(0, 1'b1, 4'd3, 4'd0, 4'd0, 16'hBEEF);
    bus.cli_req[0] = 1'b1;
    @(negedge clk);
    chk("wr_rfreq", 32'(bus.rf_req),     32'd1);
    chk("wr_rfwe",  32'(bus.rf_we),      32'd1);
    chk("wr_addrw", 32'(bus.rf_addr_w),  32'd3);
    chk("wr_data",  32'(bus.rf_data_in), 32'hBEEF);
    chk("wr_busy",  32'(bus.busy),       32'd1);
    set_cli(0, 1'b0, 4'd7, 4'd1, 4'd1, 16'h0);
    wait_ack("wr_ack", 0, cyc);
    chk("wr_lat",   32'(cyc),            32'd4);
    chk("wr_hold",  32'(bus.rf_addr_w),  32'd3);
    drop("wr_ackfall", 0);
    chk("wr_idle",  32'(bus.busy),       32'd0);
    chk("wr_weclr", 32'(bus.rf_we),      32'd0);

    // Read back r3 (ptr=1, only client 0 requests).
    set_cli(0, 1'b0, 4'd0, 4'd3, 4'd0, 16'h0);
    bus.cli_req[0] = 1'b1;
    wait_ack("rd_ack", 0, cyc);
    chk("rd_r1", 32'(bus.rdata1), 32'hBEEF);
    chk("rd_r2", 32'(bus.rdata2), 32'h0);
    drop("rd_ackfall", 0);

    // Client 1 preloads r5=0x0011; ptr returns to 0.
    set_cli(1, 1'b1, 4'd5, 4'd0, 4'd0, 16'h0011);
    bus.cli_req[1] = 1'b1;
    wait_ack("pre_ack", 1, cyc);
    chk("pre_gid", 32'(bus.grant_id), 32'd1);
    drop("pre_ackfall", 1);

    // Contention with ptr=0: client 0 first.
    set_cli(0, 1'b0, 4'd0, 4'd5, 4'd3, 16'h0);
    set_cli(1, 1'b0, 4'd0, 4'd3, 4'd5, 16'h0);
    bus.cli_req = 2'b11;
    @(negedge clk);
    chk("ca_first", 32'(bus.grant_id), 32'd0);
    wait_ack("ca_ack0", 0, cyc);
    chk("ca_ack_only0", 32'(bus.cli_ack), 32'b01);
    chk("ca_rd1_0", 32'(bus.rdata1), 32'h0011);
    chk("ca_rd2_0", 32'(bus.rdata2), 32'hBEEF);
    drop("ca_fall0", 0);
    wait_ack("ca_ack1", 1, cyc);
    chk("ca_second", 32'(bus.grant_id), 32'd1);
    chk("ca_rd1_1", 32'(bus.rdata1), 32'hBEEF);
    chk("ca_rd2_1", 32'(bus.rdata2), 32'h0011);
    drop("ca_fall1", 1);

    // Write r5=0x0022 and read r5 in the same transaction: old value.
    set_cli(0, 1'b1, 4'd5, 4'd5, 4'd0, 16'h0022);
    bus.cli_req[0] = 1'b1;
    wait_ack("rw_ack", 0, cyc);
    chk("rw_old", 32'(bus.rdata1), 32'h0011);
    drop("rw_fall", 0);

    // Contention with ptr=1: client 1 first, then client 0 reads new r5.
    set_cli(0, 1'b0, 4'd0, 4'd5, 4'd0, 16'h0);
    set_cli(1, 1'b0, 4'd0, 4'd3, 4'd0, 16'h0);
    bus.cli_req = 2'b11;
    @(negedge clk);
    chk("cb_first", 32'(bus.grant_id), 32'd1);
    wait_ack("cb_ack1", 1, cyc);
    chk("cb_rd1_1", 32'(bus.rdata1), 32'hBEEF);
    drop("cb_fall1", 1);
    wait_ack("cb_ack0", 0, cyc);
    chk("rw_new", 32'(bus.rdata1), 32'h0022);
    drop("cb_fall0", 0);

    // Slow client 1 holds req 10 cycles past ack while client 0 waits.
    set_cli(1, 1'b0, 4'd0, 4'd3, 4'd0, 16'h0);
    bus.cli_req[1] = 1'b1;
    wait_ack("slow_ack", 1, cyc);
    bus.cli_req[0] = 1'b1;
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.cli_ack == 2'b10 && bus.busy && !bus.rf_req) cnt++;
    end
    chk("slow_hold", 32'(cnt), 32'd10);
    bus.cli_req[1] = 1'b0;
    @(negedge clk);
    chk("slow_ackfall", 32'(bus.cli_ack), 32'd0);
    chk("slow_nogrant", 32'(bus.rf_req),  32'd0);
    @(negedge clk);
    chk("slow_grant",   32'(bus.rf_req),   32'd1);
    chk("slow_gid",     32'(bus.grant_id), 32'd0);
    wait_ack("slow_ack0", 0, cyc);
    drop("slow_fall0", 0);

    // Reset while ISSUE with rf_ack high; the file keeps ack asserted.
    set_cli(1, 1'b0, 4'd0, 4'd3, 4'd0, 16'h0);
    bus.cli_req[1] = 1'b1;
    cnt = 0;
    while (!bus.rf_ack && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("rs_rfack", 32'(bus.rf_ack), 32'd1);
    rf_hold = 1'b1;
    rst_n   = 1'b0;
    #1;
    chk("rs_rfreq", 32'(bus.rf_req),   32'd0);
    chk("rs_busy",  32'(bus.busy),     32'd0);
    chk("rs_gid",   32'(bus.grant_id), 32'd0);
    chk("rs_ack",   32'(bus.cli_ack),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (bus.rf_req) cnt++;
    end
    chk("rs_guard", 32'(cnt), 32'd0);
    rf_hold = 1'b0;
    @(negedge clk);
    chk("rs_guard2", 32'(bus.rf_req), 32'd0);
    chk("rs_acklow", 32'(bus.rf_ack), 32'd0);
    @(negedge clk);
    chk("rs_regrant", 32'(bus.rf_req),   32'd1);
    chk("rs_gid1",    32'(bus.grant_id), 32'd1);
    wait_ack("rs_cliack", 1, cyc);
    drop("rs_fall", 1);

    // Client 0 drops req during ISSUE: ack pulses for exactly one cycle.
    set_cli(0, 1'b1, 4'd7, 4'd0, 4'd0, 16'h1234);
    bus.cli_req[0] = 1'b1;
    @(negedge clk);
    chk("ed_gid", 32'(bus.grant_id), 32'd0);
    bus.cli_req[0] = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus.cli_ack[0]) cnt++;
    end
    chk("ed_pulse", 32'(cnt),      32'd1);
    chk("ed_idle",  32'(bus.busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_arbiter.md
# regfile_arbiter

Sequencer and round-robin arbiter that shares one `AsyncRegisterFile` between `NumReq` client units. Each client has a four-phase req/ack port carrying one write and/or two reads. The arbiter grants one client at a time and runs the full four-phase handshake on the register file. It latches the read data and then completes the client's handshake. It sits between the execute-stage clients (ALU writeback, load unit, etc.) and the register file.

## Interface
Parameters:
- `DataWidth`, 16, register data width
- `AddrWidth`, 4, register address width
- `NumReq`, 2, number of clients (≥2)
- `IdxWidth`, $clog2(NumReq), grant index width

Ports:
- `clk`  in  1  single clock; all state on its rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `cli_req`  in  NumReq  per-client four-phase request
- `cli_ack`  out  NumReq  per-client acknowledge, at most one bit high
- `cli_we`  in  NumReq  per-client write enable
- `cli_addr_w`  in  NumReq*AddrWidth  write addresses, client i at slice i
- `cli_addr_r1`, `cli_addr_r2`  in  NumReq*AddrWidth  read addresses
- `cli_data_in`  in  NumReq*DataWidth  write data
- `rdata1`, `rdata2`  out  DataWidth  captured read data, valid while any `cli_ack` high
- `grant_id`  out  IdxWidth  index of the client being served
- `busy`  out  1  high in any state other than IDLE
- `rf_req`  out  1  to register file `req`
- `rf_ack`  in  1  from register file `ack`
- `rf_we`, `rf_addr_w`, `rf_addr_r1`, `rf_addr_r2`, `rf_data_in`  out  register file command, driven from latched registers

## Operation
- States: IDLE, ISSUE, RELEASE, DONE.
- IDLE
  - Condition: some `cli_req` bit is high and `rf_ack`=0.
  - Action: the round-robin pick chooses a client g, searching from pointer `rr_ptr` upward with wrap.
  - Latched on the same edge: `grant_id`=g, g's we/addrs/data into the `rf_*` registers, `rf_req`<=1.
  - Next state: ISSUE.
- ISSUE
  - Condition: `rf_ack`=1 is sampled.
  - Action: `rdata1`<=`rf`'s `data_out1`, `rdata2`<=`data_out2`, `rf_req`<=0.
  - Next state: RELEASE.
- RELEASE
  - Condition: `rf_ack`=0 is sampled.
  - Action: `cli_ack[g]`<=1.
  - Next state: DONE.
- DONE
  - Condition: `cli_req[g]`=0 is sampled.
  - Action: `cli_ack[g]`<=0, `rr_ptr`<=(g+1) mod NumReq, `rf_we`<=0.
  - Next state: IDLE.
- `rf_*` command registers hold constant from grant through RELEASE. Client inputs may change after grant without effect.
- Fairness: a client requesting continuously is served within NumReq transactions.
- Requests from non-granted clients stay pending. They are not acknowledged.

## Timing
- Reset values: all outputs 0. State IDLE, `rr_ptr`=0, `grant_id`=0, `rdata1`/`rdata2`=0.
- With a register file that acks one cycle after `req`, the sequence is:
  - Edge E0: grant.
  - E1: file write/busy.
  - E2: capture.
  - E3: file clears.
  - E4: `cli_ack` high.
- Client latency from the sampled `cli_req` to a visible `cli_ack` is 4 cycles in this case. In general it is 2 + file ack latency + file release latency.
- After `cli_req[g]` drops, `cli_ack` falls one edge later. A new grant can issue on the following edge, so back-to-back transactions take 6 cycles each.
- Simultaneous requests: the lowest index at or above `rr_ptr` wins; the others wait.
- Write is visible in the file after E1. Reads in the same transaction return the pre-write value if the address equals `addr_w`.
- Reset mid-operation: everything returns to reset values immediately. If `rf_ack` is still high, IDLE must not issue until `rf_ack`=0 is sampled (stale busy guard).
- A client drops `cli_req` before its ack (protocol violation): the transaction still completes. `cli_ack[g]` pulses high for exactly one cycle in DONE.

## Structure
- Package `regfile_arb_pkg` holds the `arb_state_t` enum (IDLE, ISSUE, RELEASE, DONE) and the shared slice-index helper.
- Sub-module `rr_arbiter`:
  - Combinational one-hot pick from `req` and `ptr`, returning `gnt_valid` and `gnt_idx`.
  - Parameterised by `NumReq`.
- The top level contains the FSM, latches and port muxing.

## Test plan
- Single write: client 0 writes 0xBEEF to r3, then reads r3 → `rf_we`=1 with `addr_w`=3 at E0+. `cli_ack[0]` is high 4 cycles after req. A second transaction with `addr_r1`=3 returns `rdata1`=0xBEEF.
- Contention: both clients raise req in the same cycle with `rr_ptr`=0 → client 0 served first, then client 1. Next pair: client 1 is served first.
- Read/write same address: r5 preloaded with 0x0011, one transaction writes 0x0022 to r5 and reads r5 → `rdata1`=0x0011. A following read gives 0x0022.
- Slow client: client 1 holds req high 10 cycles after ack → `cli_ack[1]` stays high and `busy`=1. Client 0's pending req is not granted until 1 cycle after client 1 drops req.
- Reset mid-op: assert `rst_n`=0 in ISSUE after `rf_ack` rises → outputs all 0 immediately. After release, no new `rf_req` until `rf_ack` is seen low.
- Early drop: client 0 drops req in ISSUE → transaction completes, `cli_ack[0]` is high for exactly 1 cycle, then IDLE.
